// File: rtl/neuroset_pkg.sv
// Shared definitions for the dense-layer sequencer: FSM encoding, layout of a
// layer-table entry, default ping/pong buffer bases and the watchdog width helper.
// Pure declarations: no logic, no latency, no backpressure.
package neuroset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  // Layer-table entry layout: {in[4:0], out[3:0], nozero}
  localparam int CFG_W       = 10;
  localparam int CFG_IN_LSB  = 5;
  localparam int CFG_IN_W    = 5;
  localparam int CFG_OUT_LSB = 1;
  localparam int CFG_OUT_W   = 4;
  localparam int CFG_NZ_BIT  = 0;

  // Ping/pong pixel buffer bases
  localparam int BUF_A_DEFAULT = 0;
  localparam int BUF_B_DEFAULT = 4096;

  // Watchdog must hold TIMEOUT and be at least 12 bits wide
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 12) ? 12 : w;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer RUN-cycle counter; expired flags when the count equals LIMIT.
// Latency: count updates one cycle after enable; expired is a compare on the count.
// No backpressure: clear has priority over enable.
module seq_watchdog #(
  parameter int W     = 12,
  parameter int LIMIT = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dense_sched.sv
// Sequences up to four dense layers through one engine, ping-ponging pixel buffers.
// Latency: start to dense_en high is 2 cycles; every output is a flop.
// No backpressure: the engine signals completion with STOP; a watchdog aborts hung layers.
module dense_sched
  import neuroset_pkg::*;
#(
  parameter int NUM_LAYERS       = 3,
  parameter int SIZE_address_pix = 13,
  parameter int BUF_A            = BUF_A_DEFAULT,
  parameter int BUF_B            = BUF_B_DEFAULT,
  parameter int TIMEOUT          = 4095
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_idx,
  input  logic [CFG_W-1:0]            cfg_data,
  input  logic                        start,
  input  logic                        STOP,
  output logic                        dense_en,
  output logic [4:0]                  in,
  output logic [3:0]                  out,
  output logic [4:0]                  in_dense,
  output logic                        nozero,
  output logic [SIZE_address_pix-1:0] memstartp,
  output logic [SIZE_address_pix-1:0] memstartzap,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  layer_idx
);

  localparam int                        WD_W     = wd_width(TIMEOUT);
  localparam logic [1:0]                LAST_IDX = 2'(NUM_LAYERS - 1);
  localparam logic [SIZE_address_pix-1:0] BASE_A = SIZE_address_pix'(BUF_A);
  localparam logic [SIZE_address_pix-1:0] BASE_B = SIZE_address_pix'(BUF_B);

  state_t                        state_q, state_d;
  logic [CFG_W-1:0]              tbl_q [4];
  logic [CFG_W-1:0]              tbl_d [4];
  logic                          dense_en_q, dense_en_d;
  logic [4:0]                    in_q, in_d;
  logic [3:0]                    out_q, out_d;
  logic                          nozero_q, nozero_d;
  logic [SIZE_address_pix-1:0]   memstartp_q, memstartp_d;
  logic [SIZE_address_pix-1:0]   memstartzap_q, memstartzap_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic [1:0]                    layer_idx_q, layer_idx_d;
  logic [CFG_W-1:0]              cur_cfg;
  logic                          wd_expired;

  // Table is fixed at four slots so the 2-bit index always fits; slots at or
  // beyond NUM_LAYERS are never written and stay zero.
  assign cur_cfg = tbl_q[layer_idx_q];

  seq_watchdog #(
    .W     (WD_W),
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_SETUP),
    .enable  (state_q == ST_RUN),
    .expired (wd_expired)
  );

  // Layer-table writes, accepted only while no sequence is active
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && !busy_q && (int'(cfg_idx) < NUM_LAYERS)) begin
      tbl_d[cfg_idx] = cfg_data;
    end
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    in_d          = in_q;
    out_d         = out_q;
    nozero_d      = nozero_q;
    memstartp_d   = memstartp_q;
    memstartzap_d = memstartzap_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    layer_idx_d   = layer_idx_q;

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the old sequence
        if (start && !done_q) begin
          state_d       = ST_SETUP;
          layer_idx_d   = '0;
          memstartp_d   = BASE_A;
          memstartzap_d = BASE_B;
          err_d         = 1'b0;
          busy_d        = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d  = ST_RUN;
        in_d     = cur_cfg[CFG_IN_LSB +: CFG_IN_W];
        out_d    = cur_cfg[CFG_OUT_LSB +: CFG_OUT_W];
        nozero_d = cur_cfg[CFG_NZ_BIT];
      end
      ST_RUN: begin
        // STOP beats a same-cycle timeout
        if (STOP) begin
          state_d = ST_FLUSH;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (layer_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d       = ST_SETUP;
          layer_idx_d   = layer_idx_q + 2'd1;
          memstartp_d   = memstartzap_q;
          memstartzap_d = memstartp_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Engine runs through RUN and the one-cycle FLUSH that lets the last write land
    dense_en_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
  end

  // State, table and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        tbl_q[i] <= '0;
      end
      dense_en_q    <= 1'b0;
      in_q          <= '0;
      out_q         <= '0;
      nozero_q      <= 1'b0;
      memstartp_q   <= BASE_A;
      memstartzap_q <= BASE_B;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      layer_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      tbl_q         <= tbl_d;
      dense_en_q    <= dense_en_d;
      in_q          <= in_d;
      out_q         <= out_d;
      nozero_q      <= nozero_d;
      memstartp_q   <= memstartp_d;
      memstartzap_q <= memstartzap_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      layer_idx_q   <= layer_idx_d;
    end
  end

  assign dense_en    = dense_en_q;
  assign in          = in_q;
  assign out         = out_q;
  assign in_dense    = in_q;
  assign nozero      = nozero_q;
  assign memstartp   = memstartp_q;
  assign memstartzap = memstartzap_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign layer_idx   = layer_idx_q;

endmodule

// File: tb/tb_dense_sched.sv
// Bench for dense_sched: scoreboard of expected layer launches and end events.
// Engine model raises STOP on a chosen RUN cycle; monitor checks each launch.
// Checks are sampled on the falling clock edge.
module tb_dense_sched;

  localparam int TO  = 100;
  localparam int BA  = 0;
  localparam int BB  = 4096;
  localparam int K_LAYER = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int in_v;
    int out_v;
    int nz;
    int mp;
    int mz;
    int idx;
    int len;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_data;
  logic        start;
  logic        STOP;
  logic        dense_en;
  logic [4:0]  in_s;
  logic [3:0]  out_s;
  logic [4:0]  in_dense;
  logic        nozero;
  logic [12:0] memstartp;
  logic [12:0] memstartzap;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  layer_idx;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   stop_at  = -1;
  bit   skip_len = 0;

  dense_sched #(
    .NUM_LAYERS       (2),
    .SIZE_address_pix (13),
    .BUF_A            (BA),
    .BUF_B            (BB),
    .TIMEOUT          (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .start       (start),
    .STOP        (STOP),
    .dense_en    (dense_en),
    .in          (in_s),
    .out         (out_s),
    .in_dense    (in_dense),
    .nozero      (nozero),
    .memstartp   (memstartp),
    .memstartzap (memstartzap),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .layer_idx   (layer_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic push_layer(input int in_v, input int out_v, input int nz,
                            input int mp, input int mz, input int idx, input int len);
    exp_t e;
    e.kind = K_LAYER; e.in_v = in_v; e.out_v = out_v; e.nz = nz;
    e.mp = mp; e.mz = mz; e.idx = idx; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_evt(input int kind);
    exp_t e;
    e = '{kind, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  task automatic cfg_write(input int idx, input int in_v, input int out_v, input int nz);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_data = {5'(in_v), 4'(out_v), 1'(nz)};
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("seq_end_busy", 32'(busy), 0);
  endtask

  // Engine model: STOP on the chosen RUN cycle (counted from dense_en rising)
  initial begin
    int cnt = 0;
    STOP = 1'b0;
    forever begin
      @(negedge clk);
      if (dense_en) begin
        STOP = (cnt == stop_at);
        cnt++;
      end else begin
        STOP = 1'b0;
        cnt  = 0;
      end
    end
  end

  // Monitor: pop expectations on each launch, done pulse and error rise
  initial begin
    exp_t cur;
    bit   den_prev = 0, done_prev = 0, err_prev = 0, unstable = 0;
    int   hi_len = 0, lo_len = 0;
    cur = '{0, 0, 0, 0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (dense_en && !den_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_layer", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("layer_kind", cur.kind, K_LAYER);
          chk("layer_in", 32'(in_s), cur.in_v);
          chk("layer_in_dense", 32'(in_dense), cur.in_v);
          chk("layer_out", 32'(out_s), cur.out_v);
          chk("layer_nozero", 32'(nozero), cur.nz);
          chk("layer_memstartp", 32'(memstartp), cur.mp);
          chk("layer_memstartzap", 32'(memstartzap), cur.mz);
          chk("layer_idx", 32'(layer_idx), cur.idx);
          if (cur.idx > 0) chk("layer_gap", lo_len, 2);
        end
        hi_len   = 0;
        unstable = 0;
      end
      if (dense_en) begin
        hi_len++;
        if (32'(in_s) != cur.in_v || 32'(out_s) != cur.out_v ||
            32'(nozero) != cur.nz || 32'(memstartp) != cur.mp) unstable = 1;
      end else if (den_prev) begin
        lo_len = 1;
        if (!skip_len) begin
          chk("layer_len", hi_len, cur.len);
          chk("layer_stable", 32'(unstable), 0);
        end
      end else begin
        lo_len++;
      end
      if (done) begin
        if (done_prev) begin
          chk("done_one_cycle", 1, 0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("done_kind", cur.kind, K_DONE);
          chk("done_busy", 32'(busy), 0);
        end
      end
      if (err && !err_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("err_kind", cur.kind, K_ERR);
        end
      end
      den_prev  = dense_en;
      done_prev = done;
      err_prev  = err;
    end
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dense_en"}, 32'(dense_en), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_layer_idx"}, 32'(layer_idx), 0);
    chk({pfx, "_in"}, 32'(in_s), 0);
    chk({pfx, "_out"}, 32'(out_s), 0);
    chk({pfx, "_in_dense"}, 32'(in_dense), 0);
    chk({pfx, "_nozero"}, 32'(nozero), 0);
    chk({pfx, "_memstartp"}, 32'(memstartp), BA);
    chk({pfx, "_memstartzap"}, 32'(memstartzap), BB);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-layer sequence, STOP on RUN cycle 50; illegal writes/start mid-run
    cfg_write(0, 16, 8, 0);
    cfg_write(1, 8, 4, 1);
    stop_at = 50;
    push_layer(16, 8, 0, BA, BB, 0, 52);
    push_layer(8, 4, 1, BB, BA, 1, 52);
    push_evt(K_DONE);
    pulse_start();
    chk("lat_setup_dense_en", 32'(dense_en), 0);
    chk("lat_setup_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_run_dense_en", 32'(dense_en), 1);
    repeat (10) @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_data = 10'h3ff; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle(1000);
    pulse_start();   // start during the done cycle must not relaunch
    chk("done_start_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("a_idle_dense_en", 32'(dense_en), 0);
    chk("a_err", 32'(err), 0);
    chk("a_queue_empty", exp_q.size(), 0);

    // Engine never stops: watchdog aborts the first layer
    stop_at = -1;
    push_layer(16, 8, 0, BA, BB, 0, TO + 1);
    push_evt(K_ERR);
    pulse_start();
    wait_idle(1000);
    repeat (3) @(negedge clk);
    chk("b_err_sticky", 32'(err), 1);
    chk("b_busy", 32'(busy), 0);
    chk("b_queue_empty", exp_q.size(), 0);

    // STOP exactly on the timeout cycle: STOP wins, no error
    stop_at = TO;
    push_layer(16, 8, 0, BA, BB, 0, TO + 2);
    push_layer(8, 4, 1, BB, BA, 1, TO + 2);
    push_evt(K_DONE);
    pulse_start();
    chk("c_err_cleared", 32'(err), 0);
    wait_idle(1000);
    repeat (3) @(negedge clk);
    chk("c_err", 32'(err), 0);
    chk("c_queue_empty", exp_q.size(), 0);

    // Reset in the middle of the second layer
    stop_at = 50;
    push_layer(16, 8, 0, BA, BB, 0, 52);
    push_layer(8, 4, 1, BB, BA, 1, 52);
    pulse_start();
    n = 0;
    while (!(dense_en && layer_idx == 2'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("d_reached_layer2", 32'(dense_en && layer_idx == 2'd1), 1);
    repeat (10) @(negedge clk);
    skip_len = 1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    skip_len = 0;
    chk("d_queue_empty", exp_q.size(), 0);

    // Table was cleared by reset: relaunch starts layer 1 from BUF_A with zeros
    push_layer(0, 0, 0, BA, BB, 0, 52);
    push_layer(0, 0, 0, BB, BA, 1, 52);
    push_evt(K_DONE);
    pulse_start();
    wait_idle(1000);
    repeat (3) @(negedge clk);
    chk("e_err", 32'(err), 0);
    chk("e_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/dense_sched.md
DENSE_SCHED -- requirements
Module: dense_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, number of chained dense layers, legal range 1..4.
REQ-002 SHALL have parameter SIZE_address_pix, default 13, pixel-memory address width.
REQ-003 SHALL have parameter BUF_A, default 0, base address of ping buffer.
REQ-004 SHALL have parameter BUF_B, default 4096, base address of pong buffer.
REQ-005 SHALL have parameter TIMEOUT, default 4095, maximum RUN cycles per layer.
REQ-006 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge; reset is asynchronous and active-low.
 rst_n  in  1  asynchronous active-low reset.
 cfg_we  in  1  layer-table write strobe.
 cfg_idx  in  2  layer-table entry index.
 cfg_data  in  10  {in[4:0], out[3:0], nozero}.
 start  in  1  single-cycle launch pulse.
 STOP  in  1  dense engine layer-complete flag.
 dense_en  out  1  dense engine enable.
 in  out  5  current layer input count.
 out  out  4  current layer output count.
 in_dense  out  5  current layer group count, equal to in.
 nozero  out  1  current layer ReLU bypass.
 memstartp  out  SIZE_address_pix  read buffer base.
 memstartzap  out  SIZE_address_pix  write buffer base.
 busy  out  1  sequence active.
 done  out  1  one-cycle sequence-complete pulse.
 err  out  1  sticky timeout flag.
 layer_idx  out  2  current layer number.

Function
REQ-007 SHALL store NUM_LAYERS 10-bit table entries, written on cfg_we when busy=0; cfg_we while busy=1 SHALL be ignored; cfg_idx >= NUM_LAYERS SHALL be ignored.
REQ-008 SHALL implement FSM states IDLE, SETUP, RUN, FLUSH, NEXT.
REQ-009 IDLE: on start=1 -> SETUP; layer_idx<=0, memstartp<=BUF_A, memstartzap<=BUF_B, err<=0, busy<=1.
REQ-010 SETUP: dense_en=0; in/out/in_dense/nozero loaded from table[layer_idx]; watchdog<=0; next cycle -> RUN.
REQ-011 RUN: dense_en=1; watchdog increments each cycle; STOP=1 -> FLUSH; watchdog==TIMEOUT with STOP=0 -> IDLE, err<=1, busy<=0, dense_en<=0, no done.
REQ-012 STOP and timeout in the same cycle SHALL resolve as STOP (no error).
REQ-013 FLUSH: dense_en held 1 for exactly one cycle so the final write completes; -> NEXT.
REQ-014 NEXT: dense_en=0 (resets engine); if layer_idx==NUM_LAYERS-1 -> IDLE, done=1 for this one cycle, busy<=0; else layer_idx+1, memstartp/memstartzap swapped, -> SETUP.
REQ-015 dense_en SHALL be low for at least 2 consecutive cycles (NEXT, SETUP) between layers.
REQ-016 start while busy=1 SHALL be ignored; start in the cycle done=1 SHALL be ignored.
REQ-017 layer parameter outputs SHALL be stable for the whole RUN/FLUSH interval.
REQ-018 Watchdog SHALL be 12 bits minimum, width clog2(TIMEOUT+1).
REQ-019 All outputs SHALL be registered; latency start -> dense_en=1 is 2 cycles.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE; dense_en, busy, done, err, layer_idx, in, out, in_dense, nozero = 0; memstartp=BUF_A; memstartzap=BUF_B; table entries = 0.
REQ-021 Reset mid-RUN SHALL drop dense_en immediately with no done pulse.

Structure
REQ-022 State encoding, cfg_data field offsets and BUF_A/BUF_B defaults SHALL live in shared package neuroset_pkg.
REQ-023 Watchdog SHALL be sub-module seq_watchdog (clear, enable, expired); all else flat.

Verification
REQ-024 NUM_LAYERS=2, table {in=16,out=8,nz=0},{in=8,out=4,nz=1}, start; STOP after 50 cycles each -> layer1 memstartp=BUF_A/zap=BUF_B, layer2 swapped, done=1 one cycle, err=0.
REQ-025 STOP never asserted, TIMEOUT=100 -> dense_en falls 101 cycles after rising, err=1, busy=0, no done.
REQ-026 STOP asserted on cycle TIMEOUT -> FLUSH taken, err=0.
REQ-027 cfg_we during RUN and start while busy -> table and sequence unchanged.
REQ-028 rst_n low mid-RUN of layer 2 -> all outputs at reset values asynchronously; later start -> layer 1 from BUF_A.
